// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store path: access-size codes and LSU FSM states.
// Imported by load_store_unit, lsu_align and the execute/decode stages.
package load_store_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_RESP = 2'd1,
    RMW_WR  = 2'd2
  } lsu_state_e;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU: load extract/extend and store lane merge.
// Little-endian lanes; halfword lanes are chosen by lane[1] only.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rd_word,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [15:0]       st_data,
  output logic [DATA_W-1:0] ld_ext,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic [DATA_W-1:0] extend8(input logic [7:0] b, input logic uns);
    logic signed [7:0] sb;
    sb = b;
    return uns ? DATA_W'(b) : DATA_W'(sb);
  endfunction

  function automatic logic [DATA_W-1:0] extend16(input logic [15:0] h, input logic uns);
    logic signed [15:0] sh;
    sh = h;
    return uns ? DATA_W'(h) : DATA_W'(sh);
  endfunction

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      SZ_BYTE: ld_ext = extend8(byte_sel, unsigned_ld);
      SZ_HALF: ld_ext = extend16(half_sel, unsigned_ld);
      default: ld_ext = rd_word;
    endcase
  end

  // Only the addressed lanes take new data; the rest keep the word just read.
  always_comb begin
    merged = rd_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = st_data[7:0];
          2'd1:    merged[15:8]  = st_data[7:0];
          2'd2:    merged[23:16] = st_data[7:0];
          default: merged[31:24] = st_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = st_data;
        else         merged[15:0]  = st_data;
      end
      default: merged = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word stores in one cycle, loads and sub-word RMW stores in two.
// Optional alignment checking (misaligned output) when ALIGN_CHECK_EN is defined.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] byte_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [6:0]        ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              stall
`ifdef ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  lsu_state_e        state, state_nxt;
  logic [1:0]        sz_p0;
  logic              is_wr_p0, is_rd_p0, mis_p0, go_p0, cap_p0;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        size_p1;
  logic              uns_p1;
  logic [15:0]       wdata_p1;
  logic [DATA_W-1:0] ld_ext, merged;

  // Stage p0: request decode in IDLE; a write wins over a simultaneous read.
  assign sz_p0    = norm_size(size);
  assign is_wr_p0 = mem_write;
  assign is_rd_p0 = mem_read & ~mem_write;

`ifdef ALIGN_CHECK_EN
  assign mis_p0 = ((sz_p0 == SZ_HALF) & byte_addr[0]) |
                  ((sz_p0 == SZ_WORD) & (byte_addr[1:0] != 2'b00));
`else
  assign mis_p0 = 1'b0;
`endif

  assign go_p0 = req_valid & (is_wr_p0 | is_rd_p0) & ~mis_p0;

  always_comb begin
    state_nxt = state;
    ram_addr  = byte_addr[ADDR_W-1:2];
    ram_we    = 1'b0;
    ram_din   = store_data;
    stall     = 1'b0;
    cap_p0    = 1'b0;
    case (state)
      IDLE: begin
        if (go_p0) begin
          if (is_wr_p0 && (sz_p0 == SZ_WORD)) begin
            ram_we = 1'b1;
          end else begin
            stall     = 1'b1;
            cap_p0    = 1'b1;
            state_nxt = is_wr_p0 ? RMW_WR : LD_RESP;
          end
        end
      end
      LD_RESP: begin
        ram_addr  = addr_p1[ADDR_W-1:2];
        state_nxt = IDLE;
      end
      RMW_WR: begin
        ram_addr  = addr_p1[ADDR_W-1:2];
        ram_we    = 1'b1;
        ram_din   = merged;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // An abandoned RMW must never leak a partial write while reset is held.
    if (reset) begin
      ram_we = 1'b0;
      stall  = 1'b0;
    end
  end

  // Stage p1: captured request for the second cycle of loads and RMW stores.
  always_ff @(posedge clk) begin
    if (cap_p0) begin
      addr_p1  <= byte_addr;
      size_p1  <= sz_p0;
      uns_p1   <= unsigned_ld;
      wdata_p1 <= store_data[15:0];
    end
  end

  lsu_align u_align (
    .rd_word     (ram_dout),
    .lane        (addr_p1[1:0]),
    .size        (size_p1),
    .unsigned_ld (uns_p1),
    .st_data     (wdata_p1),
    .ld_ext      (ld_ext),
    .merged      (merged)
  );

  // Stage p2: registered load result and pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      load_valid <= 1'b0;
      load_data  <= '0;
    end else begin
      state      <= state_nxt;
      load_valid <= (state == LD_RESP);
      if (state == LD_RESP) load_data <= ld_ext;
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misaligned <= 1'b0;
    else       misaligned <= (state == IDLE) & req_valid & (mem_read | mem_write) & mis_p0;
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, multi-cycle corner sequences,
// and randomized requests against a byte-level reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, mem_read, mem_write, unsigned_ld;
  logic [1:0]  size;
  logic [8:0]  byte_addr;
  logic [31:0] store_data;
  logic [6:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din, ram_dout, load_data;
  logic        load_valid, stall;
`ifdef ALIGN_CHECK_EN
  logic        misaligned;
`endif

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .byte_addr(byte_addr), .store_data(store_data), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .load_data(load_data), .load_valid(load_valid), .stall(stall)
`ifdef ALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: synchronous read, one cycle latency.
  logic [31:0] ram [0:127];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int lv_count = 0;
  always @(negedge clk) if (load_valid === 1'b1) lv_count <= lv_count + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  bit [31:0] ref_mem [0:127];

  typedef struct { bit rd; bit wr; bit [1:0] sz; bit uns; bit [8:0] addr; bit [31:0] data; } req_t;
  typedef struct { int stall; bit we; bit [6:0] wa; bit [31:0] wd; bit ld; bit [31:0] ldv; bit mis; } res_t;
  typedef struct { req_t r; bit [31:0] pre; res_t e; } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: effect of one request on a word-addressed memory, from byte-lane arithmetic.
  function automatic res_t model(input req_t r);
    res_t e;
    bit [31:0] w;
    bit [1:0] sz;
    bit mis;
    int off, nb, v;
    e = '{default:0};
    sz = (r.sz == 2'd3) ? 2'd2 : r.sz;
    w = ref_mem[r.addr[8:2]];
    mis = 0;
`ifdef ALIGN_CHECK_EN
    mis = (r.rd || r.wr) && ((sz == 2'd1 && r.addr[0]) || (sz == 2'd2 && r.addr[1:0] != 2'd0));
`endif
    e.mis = mis;
    if (mis || !(r.rd || r.wr)) return e;
    off = (sz == 2'd0) ? int'(r.addr[1:0]) : (r.addr[1] ? 2 : 0);
    nb  = (sz == 2'd0) ? 1 : 2;
    if (r.wr) begin
      e.we = 1;
      e.wa = r.addr[8:2];
      if (sz == 2'd2) e.wd = r.data;
      else begin
        e.stall = 1;
        e.wd = w;
        for (int k = 0; k < nb; k++) e.wd[8*(off+k) +: 8] = r.data[8*k +: 8];
      end
    end else begin
      e.stall = 1;
      e.ld = 1;
      if (sz == 2'd2) e.ldv = w;
      else begin
        v = int'((w >> (8*off)) & ((nb == 1) ? 32'hFF : 32'hFFFF));
        if (!r.uns && v >= ((nb == 1) ? 128 : 32768)) v -= ((nb == 1) ? 256 : 65536);
        e.ldv = v;
      end
    end
    return e;
  endfunction

  // Presents a request (entered just after a rising edge) until it is accepted.
  task automatic issue(input req_t r, output res_t o);
    bit acc;
    int cyc;
    logic st;
    o = '{default:0};
    req_valid = 1'b1; mem_read = r.rd; mem_write = r.wr; size = r.sz;
    unsigned_ld = r.uns; byte_addr = r.addr; store_data = r.data;
    acc = 0; cyc = 0;
    while (!acc && cyc < 8) begin
      @(negedge clk);
      st = stall;
      if (ram_we === 1'b1) begin o.we = 1; o.wa = ram_addr; o.wd = ram_din; end
      if (st === 1'b1) o.stall++;
      @(posedge clk); #1;
      acc = (st === 1'b0);
      cyc++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: request at addr 0x%03h never accepted", r.addr);
    end
    o.ld  = load_valid;
    o.ldv = load_data;
`ifdef ALIGN_CHECK_EN
    o.mis = misaligned;
`endif
  endtask

  task automatic run(input req_t r, input res_t e, input string tag);
    res_t o;
    issue(r, o);
    check({tag, ".stall"}, o.stall, e.stall);
    check({tag, ".we"}, o.we, e.we);
    if (e.we) begin
      check({tag, ".waddr"}, o.wa, e.wa);
      check({tag, ".wdata"}, o.wd, e.wd);
      ref_mem[e.wa] = e.wd;
    end
    check({tag, ".lvalid"}, o.ld, e.ld);
    if (e.ld) begin
      check({tag, ".ldata"}, o.ldv, e.ldv);
      n_loads++;
    end
`ifdef ALIGN_CHECK_EN
    check({tag, ".mis"}, o.mis, e.mis);
`endif
  endtask

  task automatic run_model(input req_t r, input string tag);
    run(r, model(r), tag);
  endtask

  task automatic preload(input bit [8:0] addr, input bit [31:0] w);
    req_t r;
    r = '{rd:0, wr:1, sz:2'd2, uns:0, addr:addr, data:w};
    run_model(r, "preload");
  endtask

  initial begin
    vec_t vt[$];
    req_t r;
    res_t o;
    int t0;

    // Reset: outputs forced even with a word store presented.
    reset = 1'b1; req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'd2;
    unsigned_ld = 1'b0; byte_addr = 9'h010; store_data = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ram_we", ram_we, 1'b0);
    check("reset.stall", stall, 1'b0);
    check("reset.load_valid", load_valid, 1'b0);
    check("reset.load_data", load_data, 32'h0);
    req_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // {rd, wr, size, uns, addr, data}, preloaded word, {stall, we, waddr, wdata, ld, ldata, mis}
    vt.push_back('{'{0,1,2'd2,0,9'h010,32'hDEADBEEF}, 32'h0,        '{0,1,7'h04,32'hDEADBEEF,0,32'h0,0}});
    vt.push_back('{'{1,0,2'd0,0,9'h012,32'h0},        32'h80FF7F01, '{1,0,7'h0,32'h0,1,32'hFFFFFFFF,0}});
    vt.push_back('{'{1,0,2'd0,1,9'h012,32'h0},        32'h80FF7F01, '{1,0,7'h0,32'h0,1,32'h000000FF,0}});
    vt.push_back('{'{0,1,2'd1,0,9'h012,32'h0000ABCD}, 32'h11223344, '{1,1,7'h04,32'hABCD3344,0,32'h0,0}});
    vt.push_back('{'{1,0,2'd1,0,9'h010,32'h0},        32'h80FF7F01, '{1,0,7'h0,32'h0,1,32'h00007F01,0}});
    vt.push_back('{'{1,0,2'd1,0,9'h012,32'h0},        32'h80FF7F01, '{1,0,7'h0,32'h0,1,32'hFFFF80FF,0}});
    vt.push_back('{'{1,0,2'd1,1,9'h012,32'h0},        32'h80FF7F01, '{1,0,7'h0,32'h0,1,32'h000080FF,0}});
    vt.push_back('{'{0,1,2'd0,0,9'h013,32'h12345678}, 32'h11223344, '{1,1,7'h04,32'h78223344,0,32'h0,0}});
    vt.push_back('{'{1,0,2'd0,0,9'h011,32'h0},        32'h80FF7F01, '{1,0,7'h0,32'h0,1,32'h0000007F,0}});
    vt.push_back('{'{0,1,2'd3,0,9'h014,32'h01020304}, 32'h0,        '{0,1,7'h05,32'h01020304,0,32'h0,0}});
    vt.push_back('{'{1,1,2'd2,0,9'h018,32'hCAFEF00D}, 32'h0,        '{0,1,7'h06,32'hCAFEF00D,0,32'h0,0}});
    vt.push_back('{'{0,0,2'd2,0,9'h01C,32'h55555555}, 32'h77777777, '{0,0,7'h0,32'h0,0,32'h0,0}});
    vt.push_back('{'{1,0,2'd2,0,9'h01C,32'h0},        32'h12345678, '{1,0,7'h0,32'h0,1,32'h12345678,0}});
    vt.push_back('{'{1,1,2'd1,0,9'h022,32'h00009876}, 32'hAABBCCDD, '{1,1,7'h08,32'h9876CCDD,0,32'h0,0}});

    foreach (vt[i]) begin
      preload({vt[i].r.addr[8:2], 2'b00}, vt[i].pre);
      run(vt[i].r, vt[i].e, $sformatf("vec%0d", i));
    end

    // Back-to-back load then sub-word store: two cycles each, no bubble.
    preload(9'h010, 32'h80FF7F01);
    t0 = cyc_cnt;
    run('{1,0,2'd1,0,9'h010,32'h0}, '{1,0,7'h0,32'h0,1,32'h00007F01,0}, "b2b.lh");
    run('{0,1,2'd0,0,9'h011,32'h00000055}, '{1,1,7'h04,32'h80FF5501,0,32'h0,0}, "b2b.sb");
    check("b2b.cycles", cyc_cnt - t0, 4);
    run('{1,0,2'd2,0,9'h010,32'h0}, '{1,0,7'h0,32'h0,1,32'h80FF5501,0}, "b2b.lw");

    // Reset during the RMW write cycle: write suppressed, memory intact.
    preload(9'h014, 32'h11223344);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'd0;
    unsigned_ld = 1'b0; byte_addr = 9'h014; store_data = 32'h00000099;
    @(negedge clk);
    check("rst_rmw.idle_stall", stall, 1'b1);
    @(posedge clk); #1;
    check("rst_rmw.we_before", ram_we, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_rmw.we_forced", ram_we, 1'b0);
    check("rst_rmw.stall_forced", stall, 1'b0);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run('{1,0,2'd2,0,9'h014,32'h0}, '{1,0,7'h0,32'h0,1,32'h11223344,0}, "rst_rmw.lw");

    // Reset during LD_RESP: no pulse, load_data cleared.
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd0;
    unsigned_ld = 1'b0; byte_addr = 9'h015;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    check("rst_ld.stall_forced", stall, 1'b0);
    @(posedge clk); #1;
    check("rst_ld.load_valid", load_valid, 1'b0);
    check("rst_ld.load_data", load_data, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ld.load_valid_after", load_valid, 1'b0);

`ifdef ALIGN_CHECK_EN
    preload(9'h010, 32'h0BADF00D);
    run('{1,0,2'd2,0,9'h013,32'h0}, '{0,0,7'h0,32'h0,0,32'h0,1}, "mis.lw");
    run('{0,1,2'd1,0,9'h011,32'hFFFF}, '{0,0,7'h0,32'h0,0,32'h0,1}, "mis.sh");
    run('{1,0,2'd2,0,9'h010,32'h0}, '{1,0,7'h0,32'h0,1,32'h0BADF00D,0}, "mis.lw_ok");
`endif

    // Fill every word, then random traffic against the reference memory.
    for (int a = 0; a < 128; a++) preload(9'(a * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 9);
      r.rd   = (op <= 3) || (op == 8);
      r.wr   = (op >= 4) && (op <= 8);
      r.sz   = 2'($urandom_range(0, 3));
      r.uns  = 1'($urandom_range(0, 1));
      r.addr = 9'($urandom_range(0, 511));
      r.data = $urandom;
      run_model(r, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("load_valid_pulses", lv_count, n_loads);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
